// File: rtl/usb_rx_handshake_ctrl.sv
// usb_rx_handshake_ctrl: sequences the USB rx decoder for one transaction (PID wait, EOP wait, retries); USB_RX_STATS_EN adds NAK/timeout counters
module usb_rx_handshake_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TIMER_W = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic txn_start,
  input  logic expect_data,
  input  logic abort,
  input  logic pid_ack,
  input  logic pid_nak,
  input  logic pid_data0,
  input  logic eop_seen,
`ifdef USB_RX_STATS_EN
  input  logic stats_clr,
  output logic [15:0] nak_count,
  output logic [15:0] timeout_count,
`endif
  output logic rec_start,
  output logic rx_busy,
  output logic retry_req,
  output logic done,
  output logic [2:0] result
);
  localparam int CW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] R_MAX = CW'(MAX_RETRIES);
  localparam logic [2:0] R_ACK = 3'd0, R_DATA0 = 3'd1, R_NAK = 3'd2, R_TO = 3'd3, R_PROTO = 3'd4;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_PID, WAIT_EOP, RETRY, WAIT_RESEND, DONE} state_t;
  state_t state, nxt;
  logic [TIMER_W-1:0] timer;
  logic [CW-1:0] retry_cnt;
  logic exp_data;
  logic [2:0] pend, held;
  logic any_pid, multi_pid, pid_ok, expired, retry_ok;
  // decode of the decoder pulses and timer/retry limits
  always_comb begin
    any_pid = pid_ack | pid_nak | pid_data0;
    multi_pid = (pid_ack & pid_nak) | (pid_ack & pid_data0) | (pid_nak & pid_data0);
    pid_ok = any_pid && !multi_pid && (exp_data ? pid_data0 : !pid_data0);
    expired = timer == T_LAST;
    retry_ok = retry_cnt < R_MAX;
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state; a PID beats a coincident timeout, eop beats a coincident expiry, abort beats everything
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = txn_start ? ARM : IDLE;
      ARM:         nxt = WAIT_PID;
      WAIT_PID:    nxt = any_pid ? WAIT_EOP : expired ? (retry_ok ? RETRY : DONE) : WAIT_PID;
      WAIT_EOP:    nxt = eop_seen ? ((pend == R_NAK && retry_ok) ? RETRY : DONE) : expired ? DONE : WAIT_EOP;
      RETRY:       nxt = WAIT_RESEND;
      WAIT_RESEND: nxt = txn_start ? ARM : WAIT_RESEND;
      default:     nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // timer, retry count and pending result; pend doubles as the event kind (NAK) until DONE publishes it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
      retry_cnt <= '0;
      exp_data <= 1'b0;
      pend <= R_ACK;
      held <= R_ACK;
    end else if (!abort) begin
      if (state == IDLE && txn_start) begin
        exp_data <= expect_data;
        retry_cnt <= '0;
      end
      if (state == RETRY) retry_cnt <= retry_cnt + 1'b1;
      if (state == ARM || (state == WAIT_PID && any_pid)) timer <= '0;
      else if ((state == WAIT_PID || state == WAIT_EOP) && !expired) timer <= timer + 1'b1;
      if (state == WAIT_PID && any_pid) pend <= !pid_ok ? R_PROTO : pid_ack ? R_ACK : pid_data0 ? R_DATA0 : R_NAK;
      else if (state == WAIT_PID && expired) pend <= R_TO;
      else if (state == WAIT_EOP && !eop_seen && expired) pend <= R_PROTO;
      if (state == DONE) held <= pend;
    end
  end
  // outputs; result shows the new value during the done cycle and is held afterwards
  always_comb begin
    rx_busy = state != IDLE;
    rec_start = state == ARM && !abort;
    retry_req = state == RETRY && !abort;
    done = state == DONE && !abort;
    result = done ? pend : held;
  end
`ifdef USB_RX_STATS_EN
  logic nak_ev, to_ev;
  // NAK and timeout events, retried or final
  always_comb begin
    nak_ev = state == WAIT_EOP && eop_seen && pend == R_NAK && !abort;
    to_ev = state == WAIT_PID && expired && !any_pid && !abort;
  end
  // saturating event counters, clear wins over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset || stats_clr) begin
      nak_count <= '0;
      timeout_count <= '0;
    end else begin
      if (nak_ev && nak_count != 16'hFFFF) nak_count <= nak_count + 1'b1;
      if (to_ev && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 1'b1;
    end
  end
`endif
endmodule
